// File: rtl/vram_arbiter_pkg.sv
// Shared frame-buffer geometry, pixel type and frame-phase enum for the VRAM arbiter slice.
package vram_arbiter_pkg;

  localparam int unsigned FB_W     = 320;
  localparam int unsigned FB_H     = 240;
  localparam int unsigned FB_WORDS = FB_W * FB_H;
  localparam int unsigned HD       = 640;
  localparam int unsigned VD       = 480;

  typedef logic [11:0] pixel_t;

  typedef enum logic [0:0] {
    SCAN,
    VBLANK
  } frame_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Maps a 640x480 screen position onto a 320-wide frame-buffer word address using shifts and adds.
module fb_addr_gen #(
  parameter int unsigned AW = 17
) (
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  output logic [AW-1:0] fb_addr
);
  import vram_arbiter_pkg::*;

  logic [AW-1:0] x_half;
  logic [AW-1:0] y_half;
  logic          unused_lsb;

  // y*320 = y*256 + y*64; the 2x upscale drops the LSB of each coordinate.
  always_comb begin
    x_half     = AW'(pixel_x[9:1]);
    y_half     = AW'(pixel_y[9:1]);
    fb_addr    = (y_half << 8) + (y_half << 6) + x_half;
    unused_lsb = pixel_x[0] ^ pixel_y[0];
  end

endmodule

// File: rtl/vram_arbiter.sv
// Arbitrates one single-port frame-buffer RAM between VGA scan-out reads and a req/ack writer,
// aligns pixel colour with delayed syncs, and keeps per-frame write accounting.
module vram_arbiter #(
  parameter int unsigned FB_W = vram_arbiter_pkg::FB_W,
  parameter int unsigned FB_H = vram_arbiter_pkg::FB_H,
  parameter int unsigned AW   = 17,
  parameter int unsigned DW   = 12,
  parameter int unsigned VD   = vram_arbiter_pkg::VD
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic          visible,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          hs_in,
  input  logic          vs_in,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          vblank_only,
  output logic [DW-1:0] rgb_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          frame_done,
  output logic [15:0]   frame_wr_cnt,
  output logic          oob_err
);
  import vram_arbiter_pkg::*;

  localparam logic [AW-1:0] FbLimit = AW'(FB_W * FB_H);
  localparam logic [9:0]    VdLine  = 10'(VD);

  frame_state_t  state_q, state_d;
  logic [AW-1:0] fb_addr;
  logic [AW-1:0] addr_q;
  logic [9:0]    prev_y_q;
  logic          read_slot;
  logic          grant;
  logic          in_range;
  logic          enter_vd;
  logic          tick_d1, vis_d1, hs_d1, vs_d1;
  logic [15:0]   wr_cnt_q;

  fb_addr_gen #(
    .AW(AW)
  ) u_fb_addr_gen (
    .pixel_x(pixel_x),
    .pixel_y(pixel_y),
    .fb_addr(fb_addr)
  );

  always_comb begin
    read_slot = p_tick & visible;
    in_range  = (wr_addr < FbLimit);
    enter_vd  = (pixel_y == VdLine) && (prev_y_q != VdLine);
    grant     = !reset && !read_slot && wr_req && (!vblank_only || (state_q == VBLANK));

    state_d    = state_q;
    frame_done = 1'b0;
    unique case (state_q)
      SCAN: begin
        if (enter_vd) begin
          state_d    = VBLANK;
          frame_done = !reset;
        end
      end
      VBLANK: begin
        if (pixel_y == 10'd0) state_d = SCAN;
      end
    endcase

    wr_ack    = grant;
    mem_we    = grant && in_range;
    mem_wdata = grant ? wr_data : '0;
    // Idle slots keep the last address so the RAM bus does not toggle needlessly.
    if (reset)          mem_addr = '0;
    else if (read_slot) mem_addr = fb_addr;
    else if (grant)     mem_addr = wr_addr;
    else                mem_addr = addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SCAN;
      // Track the live line so a reset released on line VD cannot fake a frame entry.
      prev_y_q <= pixel_y;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      prev_y_q <= pixel_y;
      addr_q   <= mem_addr;
    end
  end

  // Scan-out pipeline: stage 1 captures the pixel slot, stage 2 samples the RAM read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_d1 <= 1'b0;
      vis_d1  <= 1'b0;
      hs_d1   <= 1'b0;
      vs_d1   <= 1'b0;
      rgb_out <= '0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
    end else begin
      tick_d1 <= p_tick;
      if (p_tick) vis_d1 <= visible;
      hs_d1   <= hs_in;
      vs_d1   <= vs_in;
      if (tick_d1) rgb_out <= vis_d1 ? mem_rdata : '0;
      hs_out  <= hs_d1;
      vs_out  <= vs_d1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q     <= '0;
      frame_wr_cnt <= '0;
      oob_err      <= 1'b0;
    end else begin
      if (grant && !in_range) oob_err <= 1'b1;
      if (frame_done) begin
        frame_wr_cnt <= wr_cnt_q;
        wr_cnt_q     <= grant ? 16'd1 : 16'd0;
      end else if (grant && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter: slot arbitration, scan-out latency, frame accounting.
module tb_vram_arbiter;

  logic        clk;
  logic        reset;
  logic        p_tick;
  logic        visible;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        hs_in;
  logic        vs_in;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        vblank_only;
  logic [11:0] rgb_out;
  logic        hs_out;
  logic        vs_out;
  logic        frame_done;
  logic [15:0] frame_wr_cnt;
  logic        oob_err;

  int total = 0;
  int bad   = 0;

  vram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .p_tick      (p_tick),
    .visible     (visible),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ack      (wr_ack),
    .vblank_only (vblank_only),
    .rgb_out     (rgb_out),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .frame_done  (frame_done),
    .frame_wr_cnt(frame_wr_cnt),
    .oob_err     (oob_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next active edge; inputs are then changed and checked mid-cycle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [7:0] hs_pat;
  logic [7:0] vs_pat;

  initial begin
    reset = 1'b1; p_tick = 1'b0; visible = 1'b0; pixel_x = '0; pixel_y = '0;
    hs_in = 1'b0; vs_in = 1'b0; mem_rdata = '0; wr_req = 1'b0; wr_addr = '0;
    wr_data = '0; vblank_only = 1'b0;
    hs_pat = 8'b1100_1011;
    vs_pat = 8'b0011_1000;

    // Reset state, with a write request pending that must not be acked.
    cyc();
    cyc();
    wr_req = 1'b1; wr_addr = 17'd42; wr_data = 12'h111;
    settle();
    chk("rst_ack", 32'(wr_ack), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_rgb", 32'(rgb_out), 32'd0);
    chk("rst_hs_vs", 32'({hs_out, vs_out}), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_fcnt", 32'(frame_wr_cnt), 32'd0);
    chk("rst_oob", 32'(oob_err), 32'd0);
    cyc();
    reset = 1'b0; wr_req = 1'b0;

    // Read slot at (10,6): address 3*320+5, colour appears 2 clk later, held 2 clk.
    cyc();
    pixel_x = 10'd10; pixel_y = 10'd6; visible = 1'b1; p_tick = 1'b1;
    settle();
    chk("rd_addr", 32'(mem_addr), 32'd965);
    chk("rd_we", 32'(mem_we), 32'd0);
    chk("rd_rgb_pre", 32'(rgb_out), 32'd0);
    cyc();
    p_tick = 1'b0; mem_rdata = 12'hABC;
    settle();
    chk("rd_rgb_lat1", 32'(rgb_out), 32'd0);
    cyc();
    pixel_x = 10'd12; p_tick = 1'b1; mem_rdata = 12'h000;
    settle();
    chk("rd_rgb_c0", 32'(rgb_out), 32'hABC);
    chk("rd_addr2", 32'(mem_addr), 32'd966);
    cyc();
    p_tick = 1'b0; mem_rdata = 12'h123;
    settle();
    chk("rd_rgb_c1", 32'(rgb_out), 32'hABC);
    cyc();
    settle();
    chk("rd_rgb_next", 32'(rgb_out), 32'h123);

    // Contention: read slot wins, write lands on the following clock.
    p_tick = 1'b1; wr_req = 1'b1; wr_addr = 17'd100; wr_data = 12'h5A5;
    settle();
    chk("ct_ack0", 32'(wr_ack), 32'd0);
    chk("ct_addr0", 32'(mem_addr), 32'd966);
    cyc();
    p_tick = 1'b0;
    settle();
    chk("ct_ack1", 32'(wr_ack), 32'd1);
    chk("ct_we1", 32'(mem_we), 32'd1);
    chk("ct_addr1", 32'(mem_addr), 32'd100);
    chk("ct_wdata1", 32'(mem_wdata), 32'h5A5);
    cyc();
    wr_req = 1'b0;
    settle();
    chk("idle_ack", 32'(wr_ack), 32'd0);
    chk("idle_we", 32'(mem_we), 32'd0);
    chk("idle_addr_hold", 32'(mem_addr), 32'd100);

    // Out-of-range boundary: FB_WORDS is rejected, FB_WORDS-1 is written.
    cyc();
    visible = 1'b0; wr_req = 1'b1; wr_addr = 17'd76800;
    settle();
    chk("oob_ack", 32'(wr_ack), 32'd1);
    chk("oob_we", 32'(mem_we), 32'd0);
    chk("oob_flag_pre", 32'(oob_err), 32'd0);
    cyc();
    wr_addr = 17'd76799;
    settle();
    chk("last_ack", 32'(wr_ack), 32'd1);
    chk("last_we", 32'(mem_we), 32'd1);
    chk("oob_flag", 32'(oob_err), 32'd1);

    // 34 more writes make 37 this frame.
    for (int i = 0; i < 34; i++) begin
      cyc();
      wr_addr = 17'(i * 7);
    end
    settle();
    chk("burst_ack", 32'(wr_ack), 32'd1);
    cyc();
    wr_req = 1'b0; pixel_y = 10'd480;
    settle();
    chk("f1_done", 32'(frame_done), 32'd1);
    cyc();
    settle();
    chk("f1_done_pulse", 32'(frame_done), 32'd0);
    chk("f1_cnt", 32'(frame_wr_cnt), 32'd37);
    chk("oob_sticky", 32'(oob_err), 32'd1);

    // vblank_only: request held from line 200 is acked only once VBLANK is entered.
    pixel_y = 10'd0;
    cyc();
    pixel_y = 10'd200; vblank_only = 1'b1; wr_req = 1'b1; wr_addr = 17'd500;
    settle();
    chk("vb_wait0", 32'(wr_ack), 32'd0);
    cyc();
    cyc();
    settle();
    chk("vb_wait2", 32'(wr_ack), 32'd0);
    cyc();
    pixel_y = 10'd480;
    settle();
    chk("vb_done", 32'(frame_done), 32'd1);
    chk("vb_ack_at_done", 32'(wr_ack), 32'd0);
    cyc();
    settle();
    chk("vb_ack1", 32'(wr_ack), 32'd1);
    chk("vb_cnt0", 32'(frame_wr_cnt), 32'd0);
    cyc();
    settle();
    chk("vb_ack2", 32'(wr_ack), 32'd1);
    cyc();
    settle();
    chk("vb_ack3", 32'(wr_ack), 32'd1);
    cyc();
    wr_req = 1'b0; vblank_only = 1'b0; pixel_y = 10'd0;

    // Grant coincident with frame_done belongs to the next frame.
    cyc();
    pixel_y = 10'd200;
    cyc();
    pixel_y = 10'd480; wr_req = 1'b1; wr_addr = 17'd7;
    settle();
    chk("co_done", 32'(frame_done), 32'd1);
    chk("co_ack", 32'(wr_ack), 32'd1);
    cyc();
    wr_req = 1'b0;
    settle();
    chk("co_cnt_prev", 32'(frame_wr_cnt), 32'd3);
    pixel_y = 10'd0;
    cyc();
    pixel_y = 10'd480;
    settle();
    chk("co_done2", 32'(frame_done), 32'd1);
    cyc();
    settle();
    chk("co_cnt_new", 32'(frame_wr_cnt), 32'd1);

    // Mid-frame reset while in VBLANK with a request pending.
    pixel_y = 10'd100; vblank_only = 1'b1; wr_req = 1'b1; wr_addr = 17'd9;
    hs_in = 1'b1; vs_in = 1'b1;
    settle();
    chk("pre_rst_ack", 32'(wr_ack), 32'd1);
    cyc();
    reset = 1'b1;
    settle();
    chk("in_rst_ack", 32'(wr_ack), 32'd0);
    chk("in_rst_addr", 32'(mem_addr), 32'd0);
    cyc();
    settle();
    chk("post_rst_ack", 32'(wr_ack), 32'd0);
    chk("post_rst_oob", 32'(oob_err), 32'd0);
    chk("post_rst_cnt", 32'(frame_wr_cnt), 32'd0);
    chk("post_rst_hs", 32'(hs_out), 32'd0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hs_in = hs_pat[i];
      vs_in = vs_pat[i];
      settle();
      chk("sync_hs", 32'(hs_out), (i < 2) ? 32'd0 : 32'(hs_pat[i-2]));
      chk("sync_vs", 32'(vs_out), (i < 2) ? 32'd0 : 32'(vs_pat[i-2]));
      chk("scan_noack", 32'(wr_ack), 32'd0);
      cyc();
    end
    pixel_y = 10'd480;
    settle();
    chk("rst_first_done", 32'(frame_done), 32'd1);
    cyc();
    settle();
    chk("rst_vb_ack", 32'(wr_ack), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port frame-buffer RAM (320x240, 12-bit RGB, 2x upscaled to 640x480) between two users:
  - the VGA scan-out path, which is hard real-time and driven by the sync generator's pixel_x/pixel_y/p_tick/visible;
  - a game-logic writer using a req/ack handshake.
- Emits aligned pixel colour plus delayed sync.
- Tracks frame phase and provides per-frame write accounting.

Parameters:
- FB_W, 320, frame-buffer width in words.
- FB_H, 240, frame-buffer height.
- AW, 17, RAM address width.
- DW, 12, pixel data width (RGB444).
- VD, 480, visible lines of the sync generator.

Ports:
- clk  in  1  system clock (2x pixel rate).
- reset  in  1  reset.
- p_tick  in  1  pixel enable from sync generator; pixel counters advance at the edge ending a p_tick=1 cycle.
- visible  in  1  active-video flag from sync generator.
- pixel_x  in  10  current column.
- pixel_y  in  10  current line.
- hs_in  in  1  hsync from sync generator.
- vs_in  in  1  vsync from sync generator.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, 1-clk latency.
- wr_req  in  1  writer request.
- wr_addr  in  AW  writer word address.
- wr_data  in  DW  writer data.
- wr_ack  out  1  write accepted this cycle.
- vblank_only  in  1  restrict writes to vertical blank.
- rgb_out  out  DW  pixel colour to DAC.
- hs_out  out  1  hsync aligned to rgb_out.
- vs_out  out  1  vsync aligned to rgb_out.
- frame_done  out  1  one-clk pulse at entry to vertical blank.
- frame_wr_cnt  out  16  writes accepted in the previous frame, saturating.
- oob_err  out  1  sticky out-of-range write flag.

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- Reset values:
  - All outputs are 0.
  - Frame FSM state is SCAN.
  - Pipeline registers and the internal write counter are cleared.
  - A wr_req pending during reset is not acked; the writer must hold it.
- Slot rule, per cycle:
  - Read slot when p_tick=1 and visible=1: mem_we=0, mem_addr=fb_addr.
  - Write-eligible slot otherwise.
  - Reads always win. During active video the writer waits at most 1 clk.
- fb_addr:
  - fb_addr = (pixel_y>>1)*FB_W + (pixel_x>>1).
  - Computed as (y'<<8)+(y'<<6)+x' for FB_W=320, with no multiplier. Result is AW bits.
- Write grant, combinational in an eligible slot: wr_req=1 and (vblank_only=0 or state=VBLANK).
  - On grant: wr_ack=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - mem_we=1 only if wr_addr < FB_W*FB_H. Otherwise mem_we=0, wr_ack is still 1, and oob_err is set (it stays set until reset).
  - The writer holds req/addr/data stable until it sees ack. Back-to-back requests are accepted on consecutive eligible slots.
- Idle slot (no grant): mem_we=0, mem_addr holds its previous value.
- Scan-out pipeline (total latency 2 clk from the read-slot cycle):
  - Stage 1 (edge ending the read slot): register vis_d1, hs_d1, vs_d1.
  - Stage 2 (next edge):
    - rgb_out <= vis_d1 ? mem_rdata : 0;
    - hs_out <= hs_d1;
    - vs_out <= vs_d1.
  - Non-read cycles update stage 1 only with hs/vs. rgb_out holds its value for both clocks of the pixel.
  - Net effect: hs/vs are delayed exactly 2 clk relative to hs_in/vs_in.
- Frame FSM:
  - SCAN -> VBLANK when the line counter reaches VD (pixel_y==VD, detected as a change from the registered previous pixel_y). frame_done pulses 1 clk on this transition.
  - VBLANK -> SCAN when pixel_y==0 (wrap).
  - On frame_done: frame_wr_cnt <= write counter, and the counter clears. If a grant occurs in the same cycle, that write counts toward the new frame.
  - The counter saturates at 16'hFFFF. OOB writes are counted.
- Simultaneous events: a read slot and wr_req together give no ack, and the request stays pending.
- Reset mid-frame: the FSM restarts in SCAN. The first frame_done comes at the next entry to line VD.

Decomposition:
- Shared package holds:
  - FB_W, FB_H, FB_WORDS=FB_W*FB_H;
  - HD=640, VD=480;
  - the RGB444 pixel typedef;
  - the frame-state enum {SCAN, VBLANK}.
- One natural sub-module: fb_addr_gen, a combinational shift-add address generator, reusable by the writer-side drawing logic.

Test Plan:
1. Read slot: pixel_x=10, pixel_y=6, visible=1, p_tick=1 -> mem_addr=3*320+5=965, mem_we=0. Model rdata=12'hABC -> rgb_out=12'hABC exactly 2 clk later, held for 2 clk.
2. Contention: wr_req=1 with wr_addr=100 asserted in a read-slot cycle -> wr_ack=0 that cycle. Next cycle (p_tick=0): wr_ack=1, mem_we=1, mem_addr=100.
3. vblank_only=1, wr_req held from line 200 -> no ack until 1 clk after frame_done (pixel_y=480); acks then continue every cycle during blanking.
4. wr_addr=76800 (=FB_WORDS) -> wr_ack=1, mem_we=0, oob_err=1; oob_err stays 1 until reset.
5. 37 writes in frame N -> frame_wr_cnt=37 after frame_done. A grant coincident with frame_done makes the next frame's count start at 1.
6. Reset asserted mid-line with wr_req pending -> next cycle all outputs 0 and no ack. After release, hs_out equals hs_in delayed by exactly 2 clk, and the sync output is glitch-free.
